// File: rtl/block_norm_pkg.sv
// Shared types and helpers for the block floating-point normaliser.
package block_norm_pkg;

  // Widest sample the exponent helper can scan.
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_IDX_W  = 6;

  // Life cycle of one ping-pong bank.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Bits needed to hold an exponent in 0..max_exp.
  function automatic int unsigned exp_width(input int unsigned max_exp);
    return $clog2(max_exp + 1);
  endfunction

  // Clamped count of whole STEP-bit leading-zero groups in the low data_w bits of x.
  function automatic int unsigned step_exp(input logic [MAX_DATA_W-1:0] x,
                                           input int unsigned data_w,
                                           input int unsigned step,
                                           input int unsigned max_exp);
    int unsigned lz;
    int unsigned e;
    logic        hit;
    lz  = 0;
    hit = 1'b0;
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        if (!hit && !x[MAX_IDX_W'(data_w - 1 - i)]) lz++;
        else hit = 1'b1;
      end
    end
    e = lz / step;
    if (e > max_exp) e = max_exp;
    return e;
  endfunction

endpackage

// File: rtl/block_normalizer_step_lzc.sv
// Combinational per-sample step exponent (leading zeros in STEP units, clamped).
module step_lzc
  import block_norm_pkg::*;
#(
  parameter  int unsigned DATA_W  = 40,
  parameter  int unsigned STEP    = 4,
  parameter  int unsigned MAX_EXP = 15,
  localparam int unsigned EXP_W   = exp_width(MAX_EXP)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [EXP_W-1:0]  exp_c_o
);

  // Exponent of the incoming sample.
  always_comb begin
    exp_c_o = EXP_W'(step_exp(MAX_DATA_W'(data_i), DATA_W, STEP, MAX_EXP));
  end

endmodule

// File: rtl/block_normalizer.sv
// Block floating-point normaliser: ping-pong banks, one shared exponent per block.
module block_normalizer
  import block_norm_pkg::*;
#(
  parameter  int unsigned DATA_W    = 40,
  parameter  int unsigned STEP      = 4,
  parameter  int unsigned MAX_EXP   = 15,
  parameter  int unsigned BLOCK_LEN = 8,
  localparam int unsigned EXP_W     = exp_width(MAX_EXP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_last
);

  localparam int unsigned IDX_W = $clog2(BLOCK_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  bank_state_e       bank_st_q [2];
  bank_state_e       bank_st_d [2];
  logic [EXP_W-1:0]  exp_q     [2];
  logic [EXP_W-1:0]  exp_d     [2];
  logic [DATA_W-1:0] mem_q     [2][BLOCK_LEN];

  logic              wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]  wr_idx_q,  wr_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  rd_idx_q,  rd_idx_d;
  logic              out_bank_q, out_bank_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [EXP_W-1:0]  out_exp_q,  out_exp_d;
  logic              out_last_q, out_last_d;

  logic [EXP_W-1:0]  in_exp_c;
  logic              in_fire_c, out_fire_c, wr_last_c, completing_rd_c;
  logic              slot_free_c, load_c;
  logic [EXP_W-1:0]  run_min_c, ld_exp_c;
  logic [DATA_W-1:0] rd_word_c;

  step_lzc #(
    .DATA_W  (DATA_W),
    .STEP    (STEP),
    .MAX_EXP (MAX_EXP)
  ) u_step_lzc (
    .data_i  (in_data),
    .exp_c_o (in_exp_c)
  );

  // Next-state for banks, write/read pointers and the output register.
  always_comb begin
    bank_st_d   = bank_st_q;
    exp_d       = exp_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    out_bank_d  = out_bank_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_exp_d   = out_exp_q;
    out_last_d  = out_last_q;

    in_fire_c   = in_valid && in_ready_q;
    out_fire_c  = out_valid_q && out_ready;
    wr_last_c   = (wr_idx_q == LAST_IDX);
    run_min_c   = (wr_idx_q == '0) ? in_exp_c
                : ((exp_q[wr_bank_q] < in_exp_c) ? exp_q[wr_bank_q] : in_exp_c);
    // The block being read completes on this edge; index 0 is already stored.
    completing_rd_c = in_fire_c && wr_last_c && (wr_bank_q == rd_bank_q);
    slot_free_c = !out_valid_q || out_ready;
    load_c      = slot_free_c && ((bank_st_q[rd_bank_q] == BANK_FULL) ||
                                  (bank_st_q[rd_bank_q] == BANK_DRAINING) ||
                                  completing_rd_c);
    ld_exp_c    = completing_rd_c ? run_min_c : exp_q[rd_bank_q];
    rd_word_c   = mem_q[rd_bank_q][rd_idx_q];

    // Bank whose last sample leaves the output register is free again.
    if (out_fire_c && out_last_q) bank_st_d[out_bank_q] = BANK_EMPTY;

    if (in_fire_c) begin
      exp_d[wr_bank_q] = run_min_c;
      if (wr_last_c) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_idx_d             = '0;
        wr_bank_d            = !wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
        wr_idx_d             = wr_idx_q + 1'b1;
      end
    end

    if (load_c) begin
      bank_st_d[rd_bank_q] = BANK_DRAINING;
      out_valid_d          = 1'b1;
      out_data_d           = rd_word_c << (32'(ld_exp_c) * STEP);
      out_exp_d            = ld_exp_c;
      out_last_d           = (rd_idx_q == LAST_IDX);
      out_bank_d           = rd_bank_q;
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d  = '0;
        rd_bank_d = !rd_bank_q;
      end else begin
        rd_idx_d  = rd_idx_q + 1'b1;
      end
    end else if (slot_free_c) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    in_ready_d = (bank_st_d[wr_bank_d] == BANK_EMPTY) ||
                 (bank_st_d[wr_bank_d] == BANK_FILLING);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      exp_q[0]     <= '0;
      exp_q[1]     <= '0;
      wr_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      out_bank_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_exp_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      exp_q[0]     <= exp_d[0];
      exp_q[1]     <= exp_d[1];
      wr_bank_q    <= wr_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      out_bank_q   <= out_bank_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_exp_q    <= out_exp_d;
      out_last_q   <= out_last_d;
    end
  end

  // Sample storage; contents are only meaningful while the bank state says so.
  always_ff @(posedge clk) begin
    if (in_fire_c) mem_q[wr_bank_q][wr_idx_q] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_exp   = out_exp_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_block_normalizer.sv
// Bench: two normalisers (MAX_EXP 15 and 6) on shared stimulus against a block-level model.
module tb_block_normalizer;

  localparam int unsigned DW = 40;
  localparam int unsigned ST = 4;
  localparam int unsigned BL = 4;

  typedef struct {
    logic [DW-1:0] d15;
    int unsigned   e15;
    logic [DW-1:0] d6;
    int unsigned   e6;
    bit            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready_a, out_valid_a, out_last_a;
  logic [DW-1:0] out_data_a;
  logic [3:0]    out_exp_a;
  logic          in_ready_b, out_valid_b, out_last_b;
  logic [DW-1:0] out_data_b;
  logic [2:0]    out_exp_b;

  exp_t          expq[$];
  logic [DW-1:0] part[$];
  logic [DW-1:0] pend[$];
  int            vectors = 0;
  int            miscompares = 0;
  bit            or_rand = 1'b0;
  bit            or_fix  = 1'b1;
  bit            iv_gap  = 1'b0;

  always #5 clk = ~clk;

  block_normalizer #(.DATA_W(DW), .STEP(ST), .MAX_EXP(15), .BLOCK_LEN(BL)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_exp(out_exp_a), .out_last(out_last_a));

  block_normalizer #(.DATA_W(DW), .STEP(ST), .MAX_EXP(6), .BLOCK_LEN(BL)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_exp(out_exp_b), .out_last(out_last_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Largest exponent whose shift keeps every set bit inside DW bits.
  function automatic int unsigned ref_e(input logic [DW-1:0] x, input int unsigned mx);
    int unsigned e = 0;
    while (e < mx && (e + 1) * ST <= DW && ((64'(x) >> (DW - (e + 1) * ST)) == 64'd0)) e++;
    return e;
  endfunction

  function automatic void close_block();
    int unsigned e15 = 15;
    int unsigned e6  = 6;
    exp_t h;
    foreach (part[i]) begin
      if (ref_e(part[i], 15) < e15) e15 = ref_e(part[i], 15);
      if (ref_e(part[i], 6)  < e6)  e6  = ref_e(part[i], 6);
    end
    foreach (part[i]) begin
      h.d15  = DW'(64'(part[i]) << (e15 * ST));
      h.e15  = e15;
      h.d6   = DW'(64'(part[i]) << (e6 * ST));
      h.e6   = e6;
      h.last = (i == BL - 1);
      expq.push_back(h);
    end
    part.delete();
  endfunction

  function automatic logic [DW-1:0] rnd_sample();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return DW'(r[DW-1:0] >> $urandom_range(0, DW));
  endfunction

  // One clock cycle: drive, check both DUTs against the model, then account transfers.
  task automatic cyc();
    bit   ifire, ofire, rdy;
    exp_t h;
    @(negedge clk);
    in_valid  = (pend.size() != 0) && (!iv_gap || $urandom_range(0, 2) != 0);
    in_data   = (pend.size() != 0) ? pend[0] : DW'({$urandom, $urandom});
    out_ready = or_rand ? ($urandom_range(0, 3) != 0) : or_fix;
    #1;
    rdy = (part.size() != 0) || (((expq.size() + BL - 1) / BL) < 2);
    chk("in_ready_a", 64'(in_ready_a), 64'(rdy));
    chk("in_ready_b", 64'(in_ready_b), 64'(rdy));
    chk("out_valid_a", 64'(out_valid_a), 64'(expq.size() != 0));
    chk("out_valid_b", 64'(out_valid_b), 64'(expq.size() != 0));
    if (expq.size() != 0) begin
      h = expq[0];
      chk("out_data_a", 64'(out_data_a), 64'(h.d15));
      chk("out_exp_a",  64'(out_exp_a),  64'(h.e15));
      chk("out_last_a", 64'(out_last_a), 64'(h.last));
      chk("out_data_b", 64'(out_data_b), 64'(h.d6));
      chk("out_exp_b",  64'(out_exp_b),  64'(h.e6));
      chk("out_last_b", 64'(out_last_b), 64'(h.last));
    end
    ifire = in_valid && in_ready_a;
    ofire = out_valid_a && out_ready;
    if (ofire && expq.size() != 0) void'(expq.pop_front());
    if (ifire) begin
      part.push_back(pend.pop_front());
      if (part.size() == BL) close_block();
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((pend.size() != 0 || expq.size() != 0) && k < budget) begin
      cyc();
      k++;
    end
    chk("drain_left", 64'(pend.size() + expq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string phase);
    chk({phase, "_in_ready_a"},  64'(in_ready_a),  64'd0);
    chk({phase, "_out_valid_a"}, 64'(out_valid_a), 64'd0);
    chk({phase, "_out_data_a"},  64'(out_data_a),  64'd0);
    chk({phase, "_out_exp_a"},   64'(out_exp_a),   64'd0);
    chk({phase, "_out_last_a"},  64'(out_last_a),  64'd0);
    chk({phase, "_out_valid_b"}, 64'(out_valid_b), 64'd0);
    chk({phase, "_out_data_b"},  64'(out_data_b),  64'd0);
  endtask

  // Asynchronous reset in mid-cycle; discards everything in flight.
  task automatic do_reset(input string phase);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1 check_reset_outputs(phase);
    part.delete();
    expq.delete();
    pend.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk({phase, "_ready_before_edge"}, 64'(in_ready_a), 64'd0);
  endtask

  task automatic push4(input logic [DW-1:0] a, b, c, d);
    pend.push_back(a); pend.push_back(b); pend.push_back(c); pend.push_back(d);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("por_ready_before_edge", 64'(in_ready_a), 64'd0);

    // Directed blocks with a free-running sink.
    or_fix = 1'b1;
    push4(40'h000e2b9946, 40'h00154165e9, 40'h0000000001, 40'h0000000000);
    drain(50);
    push4(40'he2b9946000, 40'h011e2b9946, 40'h0e2b994600, 40'h000e2b9946);
    push4(40'h011e2b9946, 40'h011e2b9946, 40'h011e2b9946, 40'h011e2b9946);
    drain(50);
    push4(40'h0, 40'h0, 40'h0, 40'h0);
    push4(40'h1, 40'h1, 40'h1, 40'h1);
    drain(50);

    // Backpressure: three blocks offered, sink stalled, then released.
    or_fix = 1'b0;
    repeat (12) pend.push_back(rnd_sample());
    run(20);
    or_fix = 1'b1;
    drain(80);

    // Continuous streaming over five blocks.
    repeat (5 * BL) pend.push_back(rnd_sample());
    drain(80);

    // Random valid gaps and random sink stalls.
    or_rand = 1'b1; iv_gap = 1'b1;
    repeat (12 * BL) pend.push_back(rnd_sample());
    drain(600);
    or_rand = 1'b0; iv_gap = 1'b0; or_fix = 1'b1;

    // Reset with a half-filled block.
    pend.push_back(rnd_sample()); pend.push_back(rnd_sample());
    run(3);
    do_reset("mid_fill");
    push4(40'h000e2b9946, 40'h00154165e9, 40'h0000000001, 40'h0000000000);
    drain(50);

    // Reset while a block is being drained.
    or_fix = 1'b0;
    repeat (BL) pend.push_back(rnd_sample());
    run(7);
    do_reset("mid_drain");
    or_fix = 1'b1;
    push4(40'h011e2b9946, 40'h0000000001, 40'h00154165e9, 40'h0e2b994600);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
